// File: rtl/sram_controller_pkg.sv
// Shared definitions for the data-memory SRAM controller: FSM encoding,
// default timing and the data-memory base address used by MEM_STAGE.
package sram_controller_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;
    localparam logic [31:0] DMEM_BASE_ADDR      = 32'd1024;

    // Byte offset of a data-memory access relative to the start of the SRAM window.
    function automatic logic [31:0] dmem_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one SRAM half-word phase; flags the final
// cycle (last_o) and the cycle before it (penult_o).
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          last_o,
    output logic          penult_o
);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != CNT_ZERO) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o   = (count_q == CNT_ZERO);
    assign penult_o = (count_q == CNT_ONE);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit data-memory load/store into two timed half-word accesses
// on a 16-bit asynchronous SRAM; ready stalls the pipeline while busy.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned      CNT_W      = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam int unsigned      WORD_W     = SRAM_AW - 1;

    logic [1:0]         state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [15:0]        wdata_hi_q, wdata_hi_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;

    logic               req_s;
    logic               cnt_load_s;
    logic               cnt_last_s;
    logic               cnt_penult_s;
    logic [31:0]        addr_off_s;
    logic [WORD_W-1:0]  req_word_s;
    logic               unused_addr_bits_s;

    assign req_s              = rd_en | wr_en;
    assign addr_off_s         = dmem_offset(address, BASE_ADDR);
    assign req_word_s         = addr_off_s[SRAM_AW:2];
    assign unused_addr_bits_s = ^{addr_off_s[31:SRAM_AW+1], addr_off_s[1:0]};

    sram_wait_counter #(
        .CW(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load_s),
        .load_val_i(PHASE_LOAD),
        .last_o    (cnt_last_s),
        .penult_o  (cnt_penult_s)
    );

    // WE is raised one cycle before the phase ends so addr/data are stable at its rising edge.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        cnt_load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d     = ST_LO;
                    is_wr_d     = wr_en;
                    word_d      = req_word_s;
                    wdata_hi_d  = wdata[31:16];
                    sram_addr_d = {req_word_s, 1'b0};
                    dq_out_d    = wdata[15:0];
                    dq_oe_d     = wr_en;
                    we_n_d      = ~wr_en;
                    cnt_load_s  = 1'b1;
                end else begin
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                end
            end
            ST_LO: begin
                if (cnt_last_s) begin
                    state_d     = ST_HI;
                    sram_addr_d = {word_q, 1'b1};
                    dq_out_d    = wdata_hi_q;
                    dq_oe_d     = is_wr_q;
                    we_n_d      = ~is_wr_q;
                    cnt_load_s  = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    we_n_d = ~is_wr_q | cnt_penult_s;
                end
            end
            ST_HI: begin
                if (cnt_last_s) begin
                    state_d = ST_DONE;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    we_n_d = ~is_wr_q | cnt_penult_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
                we_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= 16'h0000;
            rdata_q     <= 32'h0000_0000;
            sram_addr_q <= '0;
            dq_out_q    <= 16'h0000;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ~req_s | (state_q == ST_DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: a word-level reference memory predicts
// load data and SRAM write events; a monitor checks them as the DUT presents them.
`timescale 1ns/1ps
module tb_sram_controller;

    localparam int WAIT = 3;
    localparam int LAT  = 2 * WAIT + 1;
    localparam int AW   = 18;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    sram_controller #(
        .WAIT_CYCLES(WAIT),
        .BASE_ADDR  (32'd1024),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical SRAM: data captured when WE rises.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    logic        sram_we_prev;
    assign sram_dq_in = sram_mem[sram_addr];

    initial begin
        sram_we_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (sram_we_n && !sram_we_prev) sram_mem[sram_addr] = sram_dq_out;
            sram_we_prev = sram_we_n;
        end
    end

    typedef struct { logic [31:0] rdata; } txn_t;
    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wev_t;

    txn_t        txn_q[$];
    wev_t        wev_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    int          n_cmp;
    int          n_bad;
    bit          mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) % 32'd131072);
    endfunction

    // Monitor: completed transactions and WE pulses are popped off the scoreboard.
    initial begin
        int   busy;
        int   low_cnt;
        logic we_prev;
        txn_t t;
        wev_t ev;
        busy    = 0;
        low_cnt = 0;
        we_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!(rd_en | wr_en)) begin
                    busy = 0;
                end else if (!ready) begin
                    busy++;
                end else begin
                    if (txn_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL txn_unexpected: got completion expected none at %0t", $time);
                    end else begin
                        t = txn_q.pop_front();
                        check("rdata", rdata, t.rdata);
                        check("busy_cycles", 32'(busy), 32'(LAT));
                    end
                    busy = 0;
                end
                if (!sram_we_n) begin
                    low_cnt++;
                    check("oe_during_we", 32'(sram_dq_oe), 32'd1);
                end else if (!we_prev) begin
                    if (wev_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL wr_unexpected: got write to %0h expected none", sram_addr);
                    end else begin
                        ev = wev_q.pop_front();
                        check("wr_addr", 32'(sram_addr), 32'(ev.addr));
                        check("wr_data", 32'(sram_dq_out), 32'(ev.data));
                        check("we_pulse_len", 32'(low_cnt), 32'(WAIT - 1));
                    end
                    low_cnt = 0;
                end
            end else begin
                busy    = 0;
                low_cnt = 0;
            end
            we_prev = sram_we_n;
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wev_t ev;
        int   wd;
        wd = ref_word(a);
        ev.addr = AW'(wd * 2);     ev.data = d[15:0];  wev_q.push_back(ev);
        ev.addr = AW'(wd * 2 + 1); ev.data = d[31:16]; wev_q.push_back(ev);
        ref_mem[wd] = d;
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        int   k;
        if (w) expect_write(a, d);
        else   last_rd = ref_mem[ref_word(a)];
        t.rdata = last_rd;
        txn_q.push_back(t);
        wr_en = w; rd_en = r; address = a; wdata = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 50);
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected 1", k);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle_check(input logic [AW-1:0] exp_addr, input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
            check("idle_addr", 32'(sram_addr), 32'(exp_addr));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          gap;
        int          wsel;
        n_cmp = 0; n_bad = 0; mon_en = 0; last_rd = 32'h0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; wdata = 32'h0;
        for (int w = 0; w < 8; w++) begin
            v = $urandom;
            if (w == 1) v = 32'h1234_5678;
            ref_mem[w] = v;
            sram_mem[2 * w]     = v[15:0];
            sram_mem[2 * w + 1] = v[31:16];
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        check("ldr_1028", rdata, 32'h1234_5678);
        access(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F);
        check("both_keeps_rdata", rdata, 32'h1234_5678);
        access(1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D);
        access(1'b0, 1'b1, 32'd1036, 32'h0);
        check("str_ldr_b2b", rdata, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'h0BAD_C0DE);
        idle_check(AW'(1), 10);

        // Request withdrawn after one LO cycle: the latched store must still finish.
        expect_write(32'd1032, 32'h7777_3333);
        wr_en = 1'b1; address = 32'd1032; wdata = 32'h7777_3333;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_en = 1'b0; address = $urandom; wdata = $urandom;
        repeat (LAT) begin
            @(negedge clk);
            check("flush_ready", 32'(ready), 32'd1);
        end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        check("flush_readback", rdata, 32'h7777_3333);

        for (int i = 0; i < 40; i++) begin
            wsel = $urandom_range(0, 7);
            op   = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            a = 32'd1024 + 32'(wsel * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a + 32'h0008_0000;
            d = $urandom;
            access(op != 1, op != 0, a, d);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the last LO cycle of a store; word 100 is never read back.
        mon_en = 1'b0;
        wr_en = 1'b1; address = 32'd1024 + 32'd400; wdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_oe", 32'(sram_dq_oe), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        last_rd = 32'h0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        access(1'b0, 1'b1, 32'd1028, 32'h0);

        repeat (4) @(negedge clk);
        check("txn_q_empty", 32'(txn_q.size()), 32'd0);
        check("wev_q_empty", 32'(wev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
